// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared types, architectural reset values and init-value helper
package regfile_mp_pkg;
  localparam int GP_IDX = 28;
  localparam int SP_IDX = 29;
  localparam logic [31:0] GPAt = 32'h1000_8000;
  localparam logic [31:0] SPAt = 32'h7fff_eff0;
  typedef logic [4:0] reg_id_t;
  typedef struct packed {
    logic        en;
    reg_id_t     id;
    logic [31:0] data;
  } op_t;
  typedef enum logic {INIT, RUN} regfile_state_e;
  function automatic logic [31:0] init_val(input int idx);
    return idx == GP_IDX ? GPAt : idx == SP_IDX ? SPAt : 32'h0;
  endfunction
endpackage

// File: rtl/regfile_bypass.sv
// regfile_bypass: per-read-port write forwarding, highest write port wins, busy cleared on hit
module regfile_bypass #(
  parameter int NWRITE = 1,
  parameter int WIDTH  = 32,
  parameter int AW     = 5
) (
  input  logic [AW-1:0]    rd_id_i,
  input  logic             wr_en_i   [NWRITE],
  input  logic [AW-1:0]    wr_id_i   [NWRITE],
  input  logic [WIDTH-1:0] wr_data_i [NWRITE],
  input  logic [WIDTH-1:0] rf_data_i,
  input  logic             rf_busy_i,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o
);
  // later ports overwrite earlier matches so the highest index takes priority
  always_comb begin
    data_o = rf_data_i;
    busy_o = rf_busy_i;
    for (int k = 0; k < NWRITE; k++) begin
      if (wr_en_i[k] && wr_id_i[k] != '0 && wr_id_i[k] == rd_id_i) begin
        data_o = wr_data_i[k];
        busy_o = 1'b0;
      end
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with busy scoreboard and init walk; REGFILE_BYPASS_EN enables same-cycle forwarding
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int WIDTH  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    read_id_i    [NREAD],
  output logic [WIDTH-1:0] read_data_o  [NREAD],
  output logic             read_busy_o  [NREAD],
  input  logic             write_en_i   [NWRITE],
  input  logic [AW-1:0]    write_id_i   [NWRITE],
  input  logic [WIDTH-1:0] write_data_i [NWRITE],
  input  logic             reserve_en_i,
  input  logic [AW-1:0]    reserve_id_i,
  output logic             ready_o
);
  regfile_state_e   state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  // init walk loads one register per cycle; in RUN writes clear busy, then a reservation re-sets it
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    regs_d  = regs_q;
    busy_d  = busy_q;
    if (state_q == INIT) begin
      regs_d[idx_q] = WIDTH'(init_val(int'(idx_q)));
      busy_d[idx_q] = 1'b0;
      idx_d         = idx_q + 1'b1;
      state_d       = idx_q == AW'(NREGS - 1) ? RUN : INIT;
    end else begin
      for (int k = 0; k < NWRITE; k++) begin
        if (write_en_i[k] && write_id_i[k] != '0) begin
          regs_d[write_id_i[k]] = write_data_i[k];
          busy_d[write_id_i[k]] = 1'b0;
        end
      end
      if (reserve_en_i && reserve_id_i != '0) busy_d[reserve_id_i] = 1'b1;
    end
  end
  // reset restarts the walk and drops any write presented in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      regs_q  <= regs_d;
      busy_q  <= busy_d;
    end
  end
  assign ready_o = state_q == RUN;
  for (genvar r = 0; r < NREAD; r++) begin : g_rd
    logic [WIDTH-1:0] sel_data;
    logic             sel_busy;
`ifdef REGFILE_BYPASS_EN
    regfile_bypass #(.NWRITE(NWRITE), .WIDTH(WIDTH), .AW(AW)) u_bypass (
      .rd_id_i   (read_id_i[r]),
      .wr_en_i   (write_en_i),
      .wr_id_i   (write_id_i),
      .wr_data_i (write_data_i),
      .rf_data_i (regs_q[read_id_i[r]]),
      .rf_busy_i (busy_q[read_id_i[r]]),
      .data_o    (sel_data),
      .busy_o    (sel_busy)
    );
`else
    assign sel_data = regs_q[read_id_i[r]];
    assign sel_busy = busy_q[read_id_i[r]];
`endif
    assign read_data_o[r] = (state_q == INIT || read_id_i[r] == '0) ? '0 : sel_data;
    assign read_busy_o[r] = state_q == INIT ? 1'b1 : read_id_i[r] == '0 ? 1'b0 : sel_busy;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of init walk, writes, priority, scoreboard and reset restart
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] GPA = 32'h1000_8000;
  localparam logic [31:0] SPA = 32'h7fff_eff0;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  read_id    [2];
  logic [31:0] read_data  [2];
  logic        read_busy  [2];
  logic        write_en   [2];
  logic [4:0]  write_id   [2];
  logic [31:0] write_data [2];
  logic        reserve_en;
  logic [4:0]  reserve_id;
  logic        ready;
  int          compared = 0;
  int          mismatched = 0;

  regfile_mp #(.NREGS(32), .WIDTH(32), .NREAD(2), .NWRITE(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .read_id_i    (read_id),
    .read_data_o  (read_data),
    .read_busy_o  (read_busy),
    .write_en_i   (write_en),
    .write_id_i   (write_id),
    .write_data_i (write_data),
    .reserve_en_i (reserve_en),
    .reserve_id_i (reserve_id),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      write_en[k] = 1'b0;
      write_id[k] = '0;
      write_data[k] = '0;
      read_id[k] = '0;
    end
    reserve_en = 1'b0;
    reserve_id = '0;
  endtask

  task automatic test_reset();
    idle();
    read_id[0] = 5'd28;
    rst = 1'b1;
    step();
    step();
    compared++; if (ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready got %0b want 0", ready); end
    compared++; if (read_busy[0] !== 1'b1) begin mismatched++; $display("FAIL reset_busy got %0b want 1", read_busy[0]); end
    compared++; if (read_data[0] !== 32'h0) begin mismatched++; $display("FAIL reset_data got %h want 0", read_data[0]); end
    rst = 1'b0;
    for (int i = 0; i < 31; i++) step();
    compared++; if (ready !== 1'b0) begin mismatched++; $display("FAIL ready_early got %0b want 0 after 31 edges", ready); end
    step();
    compared++; if (ready !== 1'b1) begin mismatched++; $display("FAIL ready_rise got %0b want 1 after 32 edges", ready); end
  endtask

  task automatic test_init_values();
    read_id[0] = 5'd28;
    read_id[1] = 5'd29;
    #1;
    compared++; if (read_data[0] !== GPA) begin mismatched++; $display("FAIL init_gp got %h want %h", read_data[0], GPA); end
    compared++; if (read_data[1] !== SPA) begin mismatched++; $display("FAIL init_sp got %h want %h", read_data[1], SPA); end
    compared++; if (read_busy[1] !== 1'b0) begin mismatched++; $display("FAIL init_sp_busy got %0b want 0", read_busy[1]); end
    read_id[0] = 5'd5;
    #1;
    compared++; if (read_data[0] !== 32'h0) begin mismatched++; $display("FAIL init_r5 got %h want 0", read_data[0]); end
    compared++; if (read_busy[0] !== 1'b0) begin mismatched++; $display("FAIL init_r5_busy got %0b want 0", read_busy[0]); end
  endtask

  task automatic test_write_bypass();
    idle();
    write_en[0] = 1'b1;
    write_id[0] = 5'd7;
    write_data[0] = 32'hdead_beef;
    read_id[1] = 5'd7;
    #1;
    compared++; if (read_data[1] !== (BYP ? 32'hdead_beef : 32'h0)) begin mismatched++; $display("FAIL wr_same_cycle got %h want %h", read_data[1], BYP ? 32'hdead_beef : 32'h0); end
    step();
    write_en[0] = 1'b0;
    #1;
    compared++; if (read_data[1] !== 32'hdead_beef) begin mismatched++; $display("FAIL wr_next_cycle got %h want deadbeef", read_data[1]); end
  endtask

  task automatic test_reg0();
    idle();
    write_en[0] = 1'b1;
    write_id[0] = 5'd0;
    write_data[0] = 32'h1234;
    #1;
    compared++; if (read_data[0] !== 32'h0) begin mismatched++; $display("FAIL r0_same got %h want 0", read_data[0]); end
    step();
    write_en[0] = 1'b0;
    #1;
    compared++; if (read_data[0] !== 32'h0) begin mismatched++; $display("FAIL r0_after got %h want 0", read_data[0]); end
    compared++; if (read_busy[0] !== 1'b0) begin mismatched++; $display("FAIL r0_busy got %0b want 0", read_busy[0]); end
  endtask

  task automatic test_priority();
    idle();
    write_en[0] = 1'b1; write_id[0] = 5'd3; write_data[0] = 32'h11;
    write_en[1] = 1'b1; write_id[1] = 5'd3; write_data[1] = 32'h22;
    read_id[0] = 5'd3;
    #1;
    compared++; if (read_data[0] !== (BYP ? 32'h22 : 32'h0)) begin mismatched++; $display("FAIL prio_bypass got %h want %h", read_data[0], BYP ? 32'h22 : 32'h0); end
    step();
    write_en[0] = 1'b0;
    write_en[1] = 1'b0;
    #1;
    compared++; if (read_data[0] !== 32'h22) begin mismatched++; $display("FAIL prio_stored got %h want 22", read_data[0]); end
  endtask

  task automatic test_reserve();
    idle();
    read_id[0] = 5'd9;
    reserve_en = 1'b1;
    reserve_id = 5'd9;
    #1;
    compared++; if (read_busy[0] !== 1'b0) begin mismatched++; $display("FAIL rsv_no_bypass got %0b want 0", read_busy[0]); end
    step();
    compared++; if (read_busy[0] !== 1'b1) begin mismatched++; $display("FAIL rsv_set got %0b want 1", read_busy[0]); end
    write_en[0] = 1'b1; write_id[0] = 5'd9; write_data[0] = 32'ha5;
    #1;
    compared++; if (read_busy[0] !== !BYP) begin mismatched++; $display("FAIL rsv_wr_bypass_busy got %0b want %0b", read_busy[0], !BYP); end
    step();
    reserve_en = 1'b0;
    write_data[0] = 32'hb6;
    #1;
    compared++; if (read_data[0] !== (BYP ? 32'hb6 : 32'ha5)) begin mismatched++; $display("FAIL rsv_wr_data got %h want %h", read_data[0], BYP ? 32'hb6 : 32'ha5); end
    write_en[0] = 1'b0;
    #1;
    compared++; if (read_busy[0] !== 1'b1) begin mismatched++; $display("FAIL rsv_wins got %0b want 1", read_busy[0]); end
    compared++; if (read_data[0] !== 32'ha5) begin mismatched++; $display("FAIL rsv_wr_stored got %h want a5", read_data[0]); end
    write_en[0] = 1'b1;
    step();
    write_en[0] = 1'b0;
    #1;
    compared++; if (read_busy[0] !== 1'b0) begin mismatched++; $display("FAIL wr_clears_busy got %0b want 0", read_busy[0]); end
    compared++; if (read_data[0] !== 32'hb6) begin mismatched++; $display("FAIL wr_alone_data got %h want b6", read_data[0]); end
  endtask

  task automatic test_rst_mid_run();
    int early_ready;
    int bad_walk;
    idle();
    early_ready = 0;
    bad_walk = 0;
    reserve_en = 1'b1;
    reserve_id = 5'd9;
    step();
    read_id[0] = 5'd9;
    read_id[1] = 5'd3;
    #1;
    compared++; if (read_busy[0] !== 1'b1) begin mismatched++; $display("FAIL pre_rst_busy got %0b want 1", read_busy[0]); end
    compared++; if (read_data[1] !== 32'h22) begin mismatched++; $display("FAIL pre_rst_r3 got %h want 22", read_data[1]); end
    reserve_en = 1'b0;
    write_en[0] = 1'b1; write_id[0] = 5'd3; write_data[0] = 32'h77;
    rst = 1'b1;
    step();
    rst = 1'b0;
    write_data[0] = 32'h99;
    reserve_en = 1'b1;
    for (int i = 0; i < 31; i++) begin
      step();
      if (ready !== 1'b0) early_ready++;
      if (read_data[1] !== 32'h0 || read_busy[1] !== 1'b1) bad_walk++;
    end
    compared++; if (early_ready !== 0) begin mismatched++; $display("FAIL walk_ready got %0d early-high cycles want 0", early_ready); end
    compared++; if (bad_walk !== 0) begin mismatched++; $display("FAIL walk_reads got %0d bad cycles want 0", bad_walk); end
    write_en[0] = 1'b0;
    reserve_en = 1'b0;
    step();
    compared++; if (ready !== 1'b1) begin mismatched++; $display("FAIL rewalk_ready got %0b want 1", ready); end
    compared++; if (read_data[1] !== 32'h0) begin mismatched++; $display("FAIL rewalk_r3 got %h want 0", read_data[1]); end
    compared++; if (read_busy[0] !== 1'b0) begin mismatched++; $display("FAIL rewalk_busy9 got %0b want 0", read_busy[0]); end
    read_id[0] = 5'd28;
    #1;
    compared++; if (read_data[0] !== GPA) begin mismatched++; $display("FAIL rewalk_gp got %h want %h", read_data[0], GPA); end
  endtask

  initial begin
    test_reset();
    test_init_values();
    test_write_bypass();
    test_reg0();
    test_priority();
    test_reserve();
    test_rst_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the core's decode/writeback boundary. Provides NREAD combinational read ports, NWRITE synchronous write ports, same-cycle write-to-read bypass, and a per-register busy scoreboard for issue stalls. After reset, a sequenced init walk loads architectural reset values before the file accepts traffic.

## Interface
- NREGS, 32, number of architectural registers (power of two, ≥4)
- WIDTH, 32, data width in bits
- NREAD, 2, read ports (1–4)
- NWRITE, 1, write ports (1–2); higher index has priority
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- read_id[NREAD]  in  $clog2(NREGS)  read address per port
- read_data[NREAD]  out  WIDTH  read data per port
- read_busy[NREAD]  out  1  scoreboard bit of addressed register (bypass-aware)
- write_en[NWRITE]  in  1  write strobe per port
- write_id[NWRITE]  in  $clog2(NREGS)  write address per port
- write_data[NWRITE]  in  WIDTH  write data per port
- reserve_en  in  1  mark reserve_id busy (instruction issued with destination)
- reserve_id  in  $clog2(NREGS)  destination being reserved
- ready  out  1  high once init walk is complete

## Operation
- Register 0: reads 0, never written, never busy.
- FSM states INIT, RUN. rst → INIT, idx=0. INIT: each cycle writes init value to regs[idx], clears busy[idx], idx++; after idx=NREGS-1 → RUN. RUN stays until rst.
- Init values: regs[28]=GPAt, regs[29]=SPAt, all others 0.
- In INIT: write_en and reserve_en ignored; read_data=0, read_busy=1 for all ports.
- Write (RUN): write_en[k] && write_id[k]!=0 → regs[write_id[k]] <= write_data[k], busy cleared. Two ports same id → higher index data written.
- Reserve (RUN): reserve_en && reserve_id!=0 → busy set next edge. Same-cycle reserve and write to same id → data written, busy stays set (new reservation wins).
- Read: read_data = bypass data if any enabled write port targets read_id≠0 (highest index wins), else regs[read_id]. read_busy = busy[read_id] cleared if such a write targets it; reserve_en does not bypass into read_busy.

## Timing
- Reset values: ready=0, read_busy=1, read_data=0 on all ports.
- ready rises on the edge that completes the final init write: exactly NREGS cycles after the rst-deasserted edge.
- Read latency: combinational, 0 cycles. Write/reserve effect: next rising edge.
- rst asserted mid-INIT or mid-RUN: restart walk at idx=0 on that edge; pending writes that cycle discarded; all busy bits cleared by walk.
- idx width $clog2(NREGS); no wrap: FSM leaves INIT at terminal count.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle write-to-read bypass for read_data and read_busy as above.
- Undefined: reads return stored regs/busy only; a write is visible the cycle after its edge. Write-port priority unaffected.

## Structure
- Types package: reg_id_t, op_t, regfile_state_e {INIT, RUN}.
- Parameters package: GPAt, SPAt, GP_IDX=28, SP_IDX=29.
- One sub-module: regfile_bypass (per read port: address compare across write ports, priority select, busy override); instantiated NREAD times, omitted when REGFILE_BYPASS_EN undefined.

## Test plan
- Release rst, NREGS=32 → ready low 32 cycles then high; read_id=28/29 give GPAt/SPAt, read_id=5 gives 0, read_busy=0.
- RUN: write_en[0], id=7, data=0xDEADBEEF, read_id[1]=7 same cycle → read_data[1]=0xDEADBEEF (bypass on); undefined macro → old 0, new value next cycle.
- Write id=0 data=0x1234 → read_id=0 returns 0; read_busy=0.
- NWRITE=2, both ports id=3, data 0x11/0x22 → regs[3]=0x22, bypass shows 0x22.
- reserve id=9 → read_busy=1 next cycle; write id=9 plus reserve id=9 same cycle → data updated, busy stays 1; write alone → busy 0.
- rst pulsed at RUN with busy[9]=1, regs[3]=0x22 → ready=0 during walk, after 32 cycles regs[3]=0, busy[9]=0; writes during walk ignored.
